// File: rtl/four_bit_adder_verilog.sv
// Registered 4-bit ripple-carry adder built from four chained full-adder stages.
// {o_Cout, o_Sum} presents A + B + Cin one cycle after the operands are sampled.

module four_bit_adder_verilog_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic prop;

  assign prop = i_a ^ i_b;
  assign o_s  = prop ^ i_c;
  assign o_c  = (i_a & i_b) | (i_c & prop);

endmodule

module four_bit_adder_verilog (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_A,
  input  logic [3:0] i_B,
  input  logic       i_Cin,
  output logic [3:0] o_Sum,
  output logic       o_Cout
);

  logic [4:0] carry;
  logic [3:0] sum_bits;

  logic [3:0] sum_d;
  logic [3:0] sum_q;
  logic       cout_d;
  logic       cout_q;

  assign carry[0] = i_Cin;

  // carry[k+1] of each stage feeds the carry-in of the next
  for (genvar k = 0; k < 4; k++) begin : g_stage
    four_bit_adder_verilog_fa u_fa (
      .i_a (i_A[k]),
      .i_b (i_B[k]),
      .i_c (carry[k]),
      .o_s (sum_bits[k]),
      .o_c (carry[k+1])
    );
  end

  always_comb begin
    sum_d  = sum_bits;
    cout_d = carry[4];
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sum_q  <= 4'h0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign o_Sum  = sum_q;
  assign o_Cout = cout_q;

endmodule

// File: tb/tb_four_bit_adder_verilog.sv
// Scoreboard bench for four_bit_adder_verilog: the driver queues the expected
// 5-bit total for every edge, the monitor pops and compares after each edge.

module tb_four_bit_adder_verilog;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;

  typedef struct {
    logic [4:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  four_bit_adder_verilog dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .i_A     (a),
    .i_B     (b),
    .i_Cin   (cin),
    .o_Sum   (sum),
    .o_Cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned total of the operands, zero when reset is sampled
  function automatic logic [4:0] ref_total(input int ra, input int rb, input int rc,
                                           input bit r);
    int t;
    t = r ? 0 : ra + rb + rc;
    return t[4:0];
  endfunction

  task automatic drive(input int da, input int db, input int dc, input bit dr,
                       input string name);
    exp_t e;
    @(negedge clk);
    a   = da[3:0];
    b   = db[3:0];
    cin = dc[0];
    rst = dr;
    e.exp  = ref_total(da, db, dc, dr);
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: one result per rising edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({cout, sum} === e.exp) passed++;
        else $display("FAIL %s: got total %0d (cout=%b sum=%h) required %0d",
                      e.name, {cout, sum}, cout, sum, e.exp);
      end
    end
  end

  initial begin
    a = 4'h0; b = 4'h0; cin = 1'b0; rst = 1'b1;

    drive(0, 0, 0, 1'b1, "reset_0");
    drive(0, 0, 0, 1'b1, "reset_1");
    drive(0, 0, 0, 1'b0, "zero_0");
    drive(0, 0, 0, 1'b0, "zero_1");

    for (int i = 1; i <= 15; i++) drive(i, i, 0, 1'b0, $sformatf("double_%0d", i));

    drive(15, 0, 1, 1'b0, "f_plus_cin");
    drive(7, 8, 1, 1'b0, "7_8_cin");
    drive(0, 0, 1, 1'b0, "cin_only");
    drive(15, 15, 1, 1'b0, "max_31");

    drive(9, 9, 0, 1'b0, "pre_reset_18");
    drive(9, 9, 0, 1'b1, "mid_reset");
    drive(9, 9, 0, 1'b0, "post_reset_18");

    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
          drive(ai, bi, ci, 1'b0, $sformatf("exh_%0d_%0d_%0d", ai, bi, ci));

    for (int n = 0; n < 200; n++)
      drive($urandom_range(15), $urandom_range(15), $urandom_range(1),
            ($urandom_range(15) == 0), $sformatf("rand_%0d", n));

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d results never observed, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
